// File: rtl/lora_uart_rx.sv
// lora_uart_rx: 8N1 LSB-first UART receiver for the LoRa module serial link.
// Works with an external baud generator: bps_start enables it, and
// bps_clk is its mid-bit sample strobe. A received byte is held in a
// one-entry register and handed off with valid/ready. Frame errors and
// overruns are reported as one-cycle pulses. A watchdog aborts the frame
// if the baud generator stops pulsing.
module lora_uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int BPS_CNT   = 434,
    parameter int WDOG_CNT  = 2 * BPS_CNT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 bps_clk,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam int WDW = $clog2(WDOG_CNT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]           state;
    logic                 rx_s1, rx_s2, rx_d;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [WDW-1:0]       wdog;
    logic                 fall;
    logic                 wdog_trip;

    // A start edge is a synchronized low that was high one clock earlier.
    assign fall = ~rx_s2 & rx_d;

    // The watchdog trips when the baud generator has gone silent for
    // WDOG_CNT clocks in the middle of a frame.
    assign wdog_trip = (state != IDLE) && !bps_clk && (wdog == WDW'(WDOG_CNT - 1));

    // Two-flop synchronizer on the async line, plus a delay flop for edge detection.
    // These flops reset to the idle-high level so that reset creates no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Watchdog counter: clears on each sample strobe and counts while a frame is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (state == IDLE || bps_clk || wdog_trip) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    // Frame FSM, shift register, holding register and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bps_start <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer handshake; a load on the same clock below takes priority.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (wdog_trip) begin
                bps_start <= 1'b0;
                state     <= IDLE;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Any bps_clk seen here is ignored.
                        if (fall) begin
                            bps_start <= 1'b1;
                            state     <= START;
                        end
                    end
                    START: begin
                        if (bps_clk) begin
                            if (!rx_s2) begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end else begin
                                // The line was high at mid start bit, so this was a glitch.
                                bps_start <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                    DATA: begin
                        if (bps_clk) begin
                            shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BCW'(DATA_BITS - 1))
                                state <= STOP;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bps_clk) begin
                            // Return to IDLE at mid stop bit so that a start edge
                            // arriving back-to-back is still caught.
                            bps_start <= 1'b0;
                            state     <= IDLE;
                            if (rx_s2) begin
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        bps_start <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lora_uart_rx.sv
// Directed and randomized bench for lora_uart_rx. It contains a behavioural
// baud generator and a transaction-level model of the holding register.
`timescale 1ns/1ps
module tb_lora_uart_rx;

    localparam int DB  = 8;
    localparam int BPS = 434;
    localparam int WD  = 2 * BPS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          bps_clk = 1'b0;
    logic          rx_ready = 1'b0;
    logic          bps_start, rx_valid, frame_err, overrun;
    logic [DB-1:0] rx_data;

    always #10 clk = ~clk;

    lora_uart_rx #(.DATA_BITS(DB), .BPS_CNT(BPS), .WDOG_CNT(WD)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .bps_clk(bps_clk),
        .bps_start(bps_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
    );

    // Baud generator: the counter is held at 0 while disabled. The first strobe
    // comes about BPS/2 clocks after enable, then one strobe every BPS clocks.
    int unsigned bcnt = 0;
    bit          bps_en = 1'b1;
    always @(posedge clk) begin
        if (!bps_start) begin
            bcnt    <= 0;
            bps_clk <= 1'b0;
        end else begin
            bcnt    <= (bcnt == BPS - 1) ? 0 : bcnt + 1;
            bps_clk <= bps_en && (bcnt == BPS / 2 - 1);
        end
    end

    // Observation of the DUT on the falling edge, away from the active edge.
    int         cyc = 0, fe_cnt = 0, ov_cnt = 0, bps_runs = 0;
    int         last_bps_cyc = 0, valid_rise_cyc = 0, start_rise_cyc = 0, fe_cyc = 0, bps_hi_len = 0;
    logic       prev_valid = 1'b0, prev_start = 1'b0;
    logic [7:0] got_q[$];
    always @(negedge clk) begin
        cyc++;
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        if (overrun) ov_cnt++;
        if (bps_start && !prev_start) begin start_rise_cyc = cyc; bps_runs++; end
        if (!bps_start && prev_start) bps_hi_len = cyc - start_rise_cyc;
        if (bps_clk) last_bps_cyc = cyc;
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        prev_valid = rx_valid;
        prev_start = bps_start;
    end

    // Transaction model: a one-entry holding register plus error tallies.
    // A byte whose consumption coincides with a new load is not observable,
    // so only the bytes the monitor can see are queued.
    bit         m_valid = 1'b0;
    logic [7:0] m_data = '0;
    int         m_fe = 0, m_ov = 0;
    logic [7:0] exp_q[$];

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) m_fe++;
        else if (m_valid && !rx_ready) m_ov++;
        else if (rx_ready) begin exp_q.push_back(b); m_valid = 1'b0; end
        else begin m_valid = 1'b1; m_data = b; end
    endtask

    task automatic model_accept();
        if (m_valid) begin exp_q.push_back(m_data); m_valid = 1'b0; end
    endtask

    int passed = 0, failed = 0, total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(BPS);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    // Global bound so the run always ends.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int         glen, runs0;
        bit         found;

        // Reset state
        tick(5);
        check("rst_bps_start", bps_start, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick(BPS);

        // Frame 0xA5 with the consumer stalled
        rx_ready = 1'b0;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        check("a5_valid", rx_valid, m_valid);
        check("a5_data", rx_data, m_data);
        check("a5_fe", fe_cnt, m_fe);
        check("a5_ov", ov_cnt, m_ov);
        check("a5_valid_lat", valid_rise_cyc - last_bps_cyc, 1);
        check("a5_bps_len_9p5bits", (bps_hi_len >= 4100 && bps_hi_len <= 4150), 1);
        rx_ready = 1'b1;
        model_accept();
        tick(2);
        check("a5_valid_clr", rx_valid, 0);
        cmp_q("a5_q");

        // Short low glitch on the idle line
        glen = $urandom_range(140, 60);
        runs0 = bps_runs;
        rx = 1'b0;
        tick(glen);
        rx = 1'b1;
        tick(BPS);
        check("glitch_bps_pulsed", bps_runs, runs0 + 1);
        check("glitch_bps_off", bps_start, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_fe", fe_cnt, m_fe);

        // Bad stop bit followed by a long break, then a good frame
        rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        tick(20 * BPS);
        rx = 1'b1;
        tick(BPS);
        check("break_fe_once", fe_cnt, m_fe);
        check("break_valid", rx_valid, 0);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        check("after_break_valid", rx_valid, m_valid);
        check("after_break_data", rx_data, m_data);
        rx_ready = 1'b1;
        model_accept();
        tick(2);
        cmp_q("after_break_q");

        // Overrun: two frames with the consumer stalled
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1);
        check("ovr_count", ov_cnt, m_ov);
        check("ovr_data_kept", rx_data, m_data);
        check("ovr_valid", rx_valid, m_valid);
        rx_ready = 1'b1;
        model_accept();
        tick(1);
        check("ovr_valid_fall", rx_valid, 0);
        tick(1);
        cmp_q("ovr_q");

        // Back-to-back frames, with a handshake that coincides with a load
        rx_ready = 1'b0;
        send_frame(8'h00, 1'b1);
        model_frame(8'h00, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        rx = 1'b1;
        found = 1'b0;
        for (int i = 0; i < BPS && !found; i++) begin
            @(negedge clk);
            if (bps_clk) found = 1'b1;
        end
        #1 rx_ready = 1'b1;
        model_frame(8'hFF, 1'b1);
        check("coin_stop_strobe_seen", found, 1);
        @(posedge clk); #1;
        check("coin_valid_held", rx_valid, 1);
        check("coin_data_new", rx_data, 8'hFF);
        tick(BPS / 2);
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        rx_ready = 1'b0;
        r = 8'($urandom);
        send_frame(r, 1'b1);
        model_frame(r, 1'b1);
        check("b2b_ov", ov_cnt, m_ov);
        check("b2b_fe", fe_cnt, m_fe);
        check("b2b_rand_valid", rx_valid, m_valid);
        check("b2b_rand_data", rx_data, m_data);
        cmp_q("b2b_q");

        // Reset during data bit 4, while a byte is still held
        r = 8'($urandom);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(r[i]);
        rx = r[4];
        tick(BPS / 2);
        check("mid_bps_start", bps_start, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_bps_start", bps_start, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_fe", frame_err, 0);
        check("midrst_ov", overrun, 0);
        rx = 1'b1;
        m_valid = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(BPS);
        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        check("postrst_valid", rx_valid, m_valid);
        check("postrst_data", rx_data, m_data);
        check("postrst_fe", fe_cnt, m_fe);
        rx_ready = 1'b1;
        model_accept();
        tick(2);
        cmp_q("postrst_q");

        // Watchdog: the baud generator never pulses after a start edge
        bps_en = 1'b0;
        rx = 1'b0;
        tick(50);
        rx = 1'b1;
        for (int i = 0; i < 1200 && fe_cnt == m_fe; i++) tick(1);
        m_fe++;
        check("wdog_fe", fe_cnt, m_fe);
        check("wdog_latency", fe_cyc - start_rise_cyc, WD);
        tick(2);
        check("wdog_bps_off", bps_start, 0);
        check("wdog_valid", rx_valid, 0);
        bps_en = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
